// File: rtl/crono_set.sv
// Button-driven editor for the chronometer set value (packed BCD hh:mm:ss).
// A commit issues a one-cycle start strobe, then the value is frozen while it is written out.
module crono_set #(
    parameter int HOLD_CYCLES = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       edit_en,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       commit,
    output logic [7:0] horac,
    output logic [7:0] minc,
    output logic [7:0] segc,
    output logic       chs,
    output logic [1:0] field_sel,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT, S_HOLD} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_hist;
    logic [4:0]  w_in, w_edge;
    logic [7:0]  r_hor, r_min, r_seg;
    logic [1:0]  r_sel;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cur, w_max, w_upd;

    // Bit order: up, down, left, right, commit
    assign w_in   = {commit, btn_right, btn_left, btn_down, btn_up};
    assign w_edge = w_in & ~r_hist;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
        if (v == mx)           return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                   return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
        if (v == 8'h00)        return mx;
        else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                   return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_comb begin
        w_cur = r_seg;
        w_max = 8'h59;
        case (r_sel)
            2'd0: begin w_cur = r_hor; w_max = 8'h23; end
            2'd1: w_cur = r_min;
            default: ;
        endcase
        w_upd = w_edge[0] ? bcd_inc(w_cur, w_max) : bcd_dec(w_cur, w_max);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_edge[4]) w_next = S_COMMIT;
                      else if (edit_en) w_next = S_EDIT;
            S_EDIT:   if (w_edge[4]) w_next = S_COMMIT;
                      else if (!edit_en) w_next = S_IDLE;
            S_COMMIT: w_next = S_HOLD;
            S_HOLD:   if (r_cnt == 8'd1) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hist  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_hist  <= w_in;
            if (r_state == S_COMMIT)    r_cnt <= 8'(HOLD_CYCLES);
            else if (r_state == S_HOLD) r_cnt <= r_cnt - 8'd1;
        end
    end

    // A commit edge wins over any button edge sampled in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hor <= 8'h00;
            r_min <= 8'h00;
            r_seg <= 8'h00;
            r_sel <= 2'd0;
        end else if (r_state == S_EDIT && !w_edge[4]) begin
            if (w_edge[0] ^ w_edge[1]) begin
                case (r_sel)
                    2'd0:    r_hor <= w_upd;
                    2'd1:    r_min <= w_upd;
                    default: r_seg <= w_upd;
                endcase
            end
            if (w_edge[3] && !w_edge[2])
                r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
            else if (w_edge[2] && !w_edge[3])
                r_sel <= (r_sel == 2'd0) ? 2'd2 : r_sel - 2'd1;
        end
    end

    assign horac     = r_hor;
    assign minc      = r_min;
    assign segc      = r_seg;
    assign field_sel = r_sel;
    assign chs       = (r_state == S_COMMIT);
    assign busy      = (r_state == S_COMMIT) || (r_state == S_HOLD);
endmodule

// File: tb/tb_crono_set.sv
// Directed bench for crono_set: editing, wrap-around, field moves, commit/hold and reset abort.
module tb_crono_set;
    logic       clock = 0, reset = 1, edit_en = 0;
    logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, commit = 0;
    logic [7:0] horac, minc, segc;
    logic       chs, busy;
    logic [1:0] field_sel;
    int checks = 0, failures = 0;

    localparam logic [4:0] UP = 5'b00001, DN = 5'b00010, LF = 5'b00100, RT = 5'b01000, CM = 5'b10000;

    crono_set #(.HOLD_CYCLES(128)) dut (
        .clock(clock), .reset(reset), .edit_en(edit_en),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .commit(commit), .horac(horac), .minc(minc), .segc(segc),
        .chs(chs), .field_sel(field_sel), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] m);
        {commit, btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic press(input logic [4:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            set_btns(m);
            tick();
            set_btns(5'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        checks++; if ({horac, minc, segc} !== 24'h000000) begin failures++; $display("FAIL reset_values got=%h want=000000", {horac, minc, segc}); end
        checks++; if ({chs, busy, field_sel} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b want=0000", {chs, busy, field_sel}); end
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_hours_up();
        edit_en = 1;
        tick();
        press(UP, 5);
        checks++; if (horac !== 8'h05) begin failures++; $display("FAIL hours_up5 got=%h want=05", horac); end
        checks++; if ({minc, segc} !== 16'h0000) begin failures++; $display("FAIL hours_up5_others got=%h want=0000", {minc, segc}); end
        checks++; if (field_sel !== 2'd0) begin failures++; $display("FAIL hours_up5_sel got=%0d want=0", field_sel); end
    endtask

    task automatic test_wrap();
        press(UP, 18);
        checks++; if (horac !== 8'h23) begin failures++; $display("FAIL hours_to23 got=%h want=23", horac); end
        press(UP, 1);
        checks++; if (horac !== 8'h00) begin failures++; $display("FAIL hours_wrap_up got=%h want=00", horac); end
        press(DN, 1);
        checks++; if (horac !== 8'h23) begin failures++; $display("FAIL hours_wrap_dn got=%h want=23", horac); end
        press(RT, 1);
        press(UP, 59);
        checks++; if (minc !== 8'h59) begin failures++; $display("FAIL min_to59 got=%h want=59", minc); end
        press(UP, 1);
        checks++; if (minc !== 8'h00) begin failures++; $display("FAIL min_wrap_up got=%h want=00", minc); end
        press(DN, 1);
        checks++; if (minc !== 8'h59) begin failures++; $display("FAIL min_wrap_dn got=%h want=59", minc); end
        press(RT, 1);
        press(UP, 9);
        checks++; if (segc !== 8'h09) begin failures++; $display("FAIL sec_to09 got=%h want=09", segc); end
        press(UP, 1);
        checks++; if (segc !== 8'h10) begin failures++; $display("FAIL sec_carry got=%h want=10", segc); end
        press(DN, 1);
        checks++; if (segc !== 8'h09) begin failures++; $display("FAIL sec_borrow got=%h want=09", segc); end
        checks++; if (horac !== 8'h23) begin failures++; $display("FAIL no_cross_field got=%h want=23", horac); end
    endtask

    task automatic test_move();
        press(RT, 1);
        checks++; if (field_sel !== 2'd0) begin failures++; $display("FAIL move_right_wrap got=%0d want=0", field_sel); end
        press(LF, 1);
        checks++; if (field_sel !== 2'd2) begin failures++; $display("FAIL move_left_wrap got=%0d want=2", field_sel); end
        press(RT, 1);
        press(LF | RT, 1);
        checks++; if (field_sel !== 2'd0) begin failures++; $display("FAIL move_both got=%0d want=0", field_sel); end
        press(UP | DN, 1);
        checks++; if (horac !== 8'h23) begin failures++; $display("FAIL updown_both got=%h want=23", horac); end
        press(UP | RT, 1);
        checks++; if ({horac, 6'd0, field_sel} !== 16'h0001) begin failures++; $display("FAIL edit_and_move got=%h/%0d want=00/1", horac, field_sel); end
    endtask

    task automatic test_commit();
        int nbusy, nchs;
        reset = 1;
        tick();
        reset = 0;
        edit_en = 1;
        tick();
        press(UP, 12); press(RT, 1);
        press(UP, 34); press(RT, 1);
        press(UP, 56); press(RT, 1);
        checks++; if ({horac, minc, segc} !== 24'h123456) begin failures++; $display("FAIL setup_123456 got=%h want=123456", {horac, minc, segc}); end
        set_btns(CM);
        #1;
        checks++; if (chs !== 1'b0) begin failures++; $display("FAIL chs_before_edge got=%b want=0", chs); end
        tick();
        set_btns(5'b0);
        checks++; if ({chs, busy} !== 2'b11) begin failures++; $display("FAIL chs_after_edge got=%b want=11", {chs, busy}); end
        nbusy = 1;
        nchs = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            btn_up = (i % 2 == 0) && (i < 100);
            commit = (i == 40) || (i == 41) || (i == 90);
            tick();
            if (busy) nbusy++;
            if (chs) nchs++;
        end
        set_btns(5'b0);
        checks++; if (nbusy !== 129) begin failures++; $display("FAIL busy_width got=%0d want=129", nbusy); end
        checks++; if (nchs !== 0) begin failures++; $display("FAIL extra_chs got=%0d want=0", nchs); end
        checks++; if ({horac, minc, segc} !== 24'h123456) begin failures++; $display("FAIL hold_stable got=%h want=123456", {horac, minc, segc}); end
    endtask

    task automatic test_commit_and_up();
        int n;
        tick(); tick();
        set_btns(CM | UP);
        tick();
        set_btns(5'b0);
        checks++; if (chs !== 1'b1) begin failures++; $display("FAIL commit_up_chs got=%b want=1", chs); end
        checks++; if (horac !== 8'h12) begin failures++; $display("FAIL commit_up_value got=%h want=12", horac); end
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_timeout got=%b want=0", busy); end
    endtask

    task automatic test_idle();
        edit_en = 0;
        tick();
        press(UP, 3); press(DN, 1); press(RT, 2);
        checks++; if ({horac, minc, segc} !== 24'h123456) begin failures++; $display("FAIL idle_ignore got=%h want=123456", {horac, minc, segc}); end
        checks++; if (field_sel !== 2'd0) begin failures++; $display("FAIL idle_sel got=%0d want=0", field_sel); end
    endtask

    task automatic test_reset_hold();
        press(CM, 1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL idle_commit_busy got=%b want=1", busy); end
        repeat (39) tick();
        reset = 1;
        #1;
        checks++; if ({chs, busy} !== 2'b00) begin failures++; $display("FAIL rst_hold_ctrl got=%b want=00", {chs, busy}); end
        checks++; if ({horac, minc, segc} !== 24'h000000) begin failures++; $display("FAIL rst_hold_vals got=%h want=000000", {horac, minc, segc}); end
        tick();
        reset = 0;
        tick();
        press(UP, 2);
        checks++; if ({busy, horac} !== 9'h000) begin failures++; $display("FAIL rst_back_idle got=%b/%h want=0/00", busy, horac); end
    endtask

    initial begin
        test_reset();
        test_hours_up();
        test_wrap();
        test_move();
        test_commit();
        test_commit_and_up();
        test_idle();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crono_set.md
Name: crono_set

Overview:
- Upstream editing stage for the chronometer write path.
- Holds the user-set chronometer value as three packed-BCD bytes: hours, minutes, seconds.
- Edits the value from pre-debounced, pre-synchronised push-buttons.
- On commit, issues the single-cycle start strobe `chs` to the downstream RTC bus-write sequencer.
- Freezes the value while the downstream sequencer transfers it.

Parameters:
- HOLD_CYCLES, 128: cycles the block stays locked after a commit. Must cover the downstream three-register write sequence, which is at least 105 cycles. Legal range 1..255.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- edit_en  input  1  level; high requests edit mode
- btn_up  input  1  level; rising edge increments the selected field
- btn_down  input  1  level; rising edge decrements the selected field
- btn_left  input  1  level; rising edge selects the previous field
- btn_right  input  1  level; rising edge selects the next field
- commit  input  1  level; rising edge requests transfer to the RTC
- horac  output  8  hours, packed BCD, 00..23
- minc  output  8  minutes, packed BCD, 00..59
- segc  output  8  seconds, packed BCD, 00..59
- chs  output  1  one-cycle start strobe to the downstream sequencer
- field_sel  output  2  selected field: 0 = hours, 1 = minutes, 2 = seconds; 3 never driven
- busy  output  1  high during COMMIT and HOLD

Behaviour:
- Reset (asynchronous, immediate):
  - horac = minc = segc = 8'h00, chs = 0, field_sel = 0, busy = 0.
  - State = IDLE, hold counter = 0, all button-history registers = 0.
  - Reset asserted mid-COMMIT or mid-HOLD aborts it; chs drops immediately.
- Edge detection:
  - Each button, and commit, has a history register updated every clock in every state.
  - edge = input & ~history.
  - A held level produces exactly one edge.
  - An input already high when reset deasserts produces an edge on the first clock after release.
- Latency: every registered effect of an edge (value, field_sel, chs, state) is visible after the same clock edge on which the edge is sampled.
- States:
  - IDLE: buttons ignored.
    - edit_en = 1 -> EDIT.
    - commit edge -> COMMIT (takes priority over edit_en).
  - EDIT: buttons act as below.
    - commit edge -> COMMIT (takes priority over any button edge in the same cycle; that button edge is discarded).
    - edit_en = 0 -> IDLE; values are kept.
  - COMMIT: one cycle. chs = 1, busy = 1. Hold counter loaded with HOLD_CYCLES. Next state is HOLD.
  - HOLD: chs = 0, busy = 1. Counter decrements each cycle.
    - When the counter reaches 1, the next state is IDLE.
    - All button and commit edges are ignored, not queued.
    - horac, minc and segc are guaranteed stable.
- Field move:
  - right: field_sel 0 -> 1 -> 2 -> 0.
  - left: field_sel 0 -> 2 -> 1 -> 0.
  - left and right edges in the same cycle: no change.
- Value edit (selected field only):
  - Arithmetic is BCD per digit: low digit 9 -> 0 with carry into the high digit; borrow likewise.
  - Hours: up 23 -> 00; down 00 -> 23.
  - Minutes and seconds: up 59 -> 00; down 00 -> 59.
  - No carry or borrow propagates into an adjacent field.
  - up and down edges in the same cycle: no change.
  - A field edit and a field move in the same cycle: the edit applies to the old field_sel, and the move takes effect on the same clock.
- Output invariant: output bytes are always valid BCD within range. No non-BCD nibble is ever produced.
- Timing from commit edge to chs: 1 clock. chs width is exactly 1 cycle. busy width is HOLD_CYCLES + 1 cycles.

Test Plan:
- Reset then edit_en = 1, five up edges on hours -> horac = 8'h05, minc = segc = 8'h00, field_sel = 0.
- Hours at 8'h23, up edge -> 8'h00; one further down edge -> 8'h23. Minutes at 8'h59, up edge -> 8'h00; seconds at 8'h09, up edge -> 8'h10.
- field_sel = 0, left edge -> field_sel = 2. Then right edge -> 0. Simultaneous left + right -> stays 0. Simultaneous up + down -> value unchanged.
- Values 8'h12 / 8'h34 / 8'h56, commit edge -> chs = 1 for exactly one cycle, one clock after the edge; busy high for 129 cycles (default). Up edges and a second commit edge during busy -> outputs unchanged and no second chs.
- Commit edge and up edge in the same cycle in EDIT -> chs pulse; value not incremented. edit_en low while in IDLE with buttons toggling -> no value change.
- Reset asserted 40 cycles into HOLD -> busy = 0, chs = 0 and all values 8'h00 without waiting for a clock; the block returns to IDLE.
